// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared pipeline control types: sequencer state encoding, register-zero
// constant and the bundle of per-stage stall/flush controls.
package pipeline_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALT     = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic ex_mem_flush;
    logic mem_wb_stall;
    logic mem_wb_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, default: 1'b0};

  // Everything up to EX_MEM holds while MEM_WB takes a bubble.
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_stall: 1'b1, if_id_flush: 1'b0,
                                    id_ex_stall: 1'b1, id_ex_flush: 1'b0,
                                    ex_mem_stall: 1'b1, ex_mem_flush: 1'b0,
                                    mem_wb_stall: 1'b0, mem_wb_flush: 1'b1};

  localparam ctrl_t CTRL_RESET = '{pc_write: 1'b0, if_id_stall: 1'b0, if_id_flush: 1'b1,
                                   id_ex_stall: 1'b0, id_ex_flush: 1'b1,
                                   ex_mem_stall: 1'b0, ex_mem_flush: 1'b1,
                                   mem_wb_stall: 1'b0, mem_wb_flush: 1'b1};

  function automatic ctrl_t ctrl_run(input logic branch_taken, input logic load_use);
    ctrl_t c;
    c = CTRL_NORMAL;
    if (branch_taken) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_write    = 1'b0;
      c.if_id_stall = 1'b1;
      c.id_ex_flush = 1'b1;
    end else begin
      c = CTRL_NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction in ID.
module hazard_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic       id_ex_memread_i,
  input  logic [4:0] id_ex_rt_i,
  input  logic [4:0] if_id_rs_i,
  input  logic [4:0] if_id_rt_i,
  output logic       load_use_o
);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use_o = id_ex_memread_i && (id_ex_rt_i != REG_ZERO) &&
                      ((id_ex_rt_i == if_id_rs_i) || (id_ex_rt_i == if_id_rt_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: load-use bubbles,
// branch squash, data-memory wait with timeout, and debug halt/resume.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_ex_memread,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             branch_taken,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_write,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             mem_wb_stall,
  output logic             mem_wb_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count
);

  localparam int                WAIT_W      = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT  = WAIT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_MAX     = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_timeout_q, mem_timeout_d;
  logic               halt_pending_q, halt_pending_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;
  ctrl_t              ctrl_s;
  logic               halted_s;
  logic               load_use_s;
  logic               mem_busy_s;
  logic               count_en_s;

  hazard_detect u_hazard_detect (
    .id_ex_memread_i (id_ex_memread),
    .id_ex_rt_i      (id_ex_rt),
    .if_id_rs_i      (if_id_rs),
    .if_id_rt_i      (if_id_rt),
    .load_use_o      (load_use_s)
  );

  assign mem_busy_s = dmem_req && !dmem_ready;

  // Sequencer state, wait counter, sticky timeout and stall counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= {WAIT_W{1'b0}};
      mem_timeout_q  <= 1'b0;
      halt_pending_q <= 1'b0;
      stall_count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_timeout_q  <= mem_timeout_d;
      halt_pending_q <= halt_pending_d;
      stall_count_q  <= stall_count_d;
    end
  end

  // Next-state and control decode; outputs act in the same cycle as their cause.
  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_timeout_d  = mem_timeout_q;
    halt_pending_d = halt_pending_q;
    ctrl_s         = ctrl_run(branch_taken, load_use_s);
    halted_s       = 1'b0;
    if (reset) begin
      ctrl_s = CTRL_RESET;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_busy_s) begin
            ctrl_s     = CTRL_FREEZE;
            state_d    = ST_MEM_WAIT;
            wait_cnt_d = WAIT_W'(1);
          end else if (halt_req) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_MEM_WAIT: begin
          if (halt_req) begin
            halt_pending_d = 1'b1;
          end else begin
            halt_pending_d = halt_pending_q;
          end
          // A ready in the timeout cycle still completes the access normally.
          if (dmem_ready) begin
            wait_cnt_d = {WAIT_W{1'b0}};
            state_d    = (halt_pending_q || halt_req) ? ST_HALT : ST_RUN;
          end else begin
            ctrl_s = CTRL_FREEZE;
            if (wait_cnt_q == WAIT_LIMIT) begin
              state_d       = ST_HALT;
              mem_timeout_d = 1'b1;
              wait_cnt_d    = {WAIT_W{1'b0}};
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
        end
        ST_HALT: begin
          ctrl_s   = CTRL_FREEZE;
          halted_s = 1'b1;
          if (resume && !mem_timeout_q && !halt_req) begin
            state_d        = ST_RUN;
            halt_pending_d = 1'b0;
          end else begin
            state_d = ST_HALT;
          end
        end
        default: begin
          ctrl_s     = CTRL_FREEZE;
          state_d    = ST_RUN;
          wait_cnt_d = {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // Saturating count of frozen-PC cycles, excluding debug halt time.
  always_comb begin
    count_en_s = !reset && !ctrl_s.pc_write &&
                 ((state_q == ST_RUN) || (state_q == ST_MEM_WAIT));
    if (count_en_s && (stall_count_q != CNT_MAX)) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end else begin
      stall_count_d = stall_count_q;
    end
  end

  assign pc_write     = ctrl_s.pc_write;
  assign if_id_stall  = ctrl_s.if_id_stall;
  assign if_id_flush  = ctrl_s.if_id_flush;
  assign id_ex_stall  = ctrl_s.id_ex_stall;
  assign id_ex_flush  = ctrl_s.id_ex_flush;
  assign ex_mem_stall = ctrl_s.ex_mem_stall;
  assign ex_mem_flush = ctrl_s.ex_mem_flush;
  assign mem_wb_stall = ctrl_s.mem_wb_stall;
  assign mem_wb_flush = ctrl_s.mem_wb_flush;
  assign halted       = halted_s;
  assign mem_timeout  = mem_timeout_q;
  assign stall_count  = stall_count_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed-vector bench for pipeline_hazard_ctrl with MEM_TIMEOUT=4.
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W = 16;

  // Control vector order: pc, if_id s/f, id_ex s/f, ex_mem s/f, mem_wb s/f.
  localparam logic [8:0] C_RESET  = 9'b0_01_01_01_01;
  localparam logic [8:0] C_FREEZE = 9'b0_10_10_10_01;
  localparam logic [8:0] C_NORMAL = 9'b1_00_00_00_00;
  localparam logic [8:0] C_BRANCH = 9'b1_01_01_00_00;
  localparam logic [8:0] C_LDUSE  = 9'b0_10_01_00_00;

  logic clk, reset;
  logic id_ex_memread, branch_taken, dmem_req, dmem_ready, halt_req, resume;
  logic [4:0] id_ex_rt, if_id_rs, if_id_rt;
  logic pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush;
  logic halted, mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [8:0] ctrl_w;

  int n_cmp = 0;
  int n_bad = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .id_ex_memread(id_ex_memread), .id_ex_rt(id_ex_rt),
    .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .branch_taken(branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .halt_req(halt_req), .resume(resume),
    .pc_write(pc_write), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
    .ex_mem_flush(ex_mem_flush), .mem_wb_stall(mem_wb_stall), .mem_wb_flush(mem_wb_flush),
    .halted(halted), .mem_timeout(mem_timeout), .stall_count(stall_count)
  );

  assign ctrl_w = {pc_write, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
                   ex_mem_stall, ex_mem_flush, mem_wb_stall, mem_wb_flush};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; id_ex_memread = 1'b0; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0;
    branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0; resume = 1'b0;
    #2;
    check_eq("rst_ctrl", 32'(ctrl_w), 32'(C_RESET));
    check_eq("rst_halted", 32'(halted), 32'd0);
    tick();
    check_eq("rst_cnt", 32'(stall_count), 32'd0);
    check_eq("rst_tmo", 32'(mem_timeout), 32'd0);
    reset = 1'b0; #1;
    check_eq("idle_ctrl", 32'(ctrl_w), 32'(C_NORMAL));
    tick();

    // lw $2 in EX, add $3,$2,$4 in ID: one bubble.
    id_ex_memread = 1'b1; id_ex_rt = 5'd2; if_id_rs = 5'd2; if_id_rt = 5'd4; #1;
    check_eq("lduse_ctrl", 32'(ctrl_w), 32'(C_LDUSE));
    tick();
    id_ex_memread = 1'b0; id_ex_rt = 5'd0; #1;
    check_eq("lduse_after", 32'(ctrl_w), 32'(C_NORMAL));
    check_eq("lduse_cnt", 32'(stall_count), 32'd1);
    tick();

    // Load to $0 never stalls.
    id_ex_memread = 1'b1; id_ex_rt = 5'd0; if_id_rs = 5'd0; if_id_rt = 5'd0; #1;
    check_eq("r0_ctrl", 32'(ctrl_w), 32'(C_NORMAL));
    tick();

    // Branch beats load-use.
    id_ex_rt = 5'd5; if_id_rs = 5'd5; branch_taken = 1'b1; #1;
    check_eq("br_ctrl", 32'(ctrl_w), 32'(C_BRANCH));
    tick();
    id_ex_memread = 1'b0; branch_taken = 1'b0; #1;
    check_eq("br_cnt", 32'(stall_count), 32'd1);
    tick();

    // Memory wait of 3 cycles, release on the 4th.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; check_eq("mw_ctrl", 32'(ctrl_w), 32'(C_FREEZE));
      tick();
    end
    dmem_ready = 1'b1; #1;
    check_eq("mw_release", 32'(ctrl_w), 32'(C_NORMAL));
    tick();
    dmem_req = 1'b0; dmem_ready = 1'b0; #1;
    check_eq("mw_cnt", 32'(stall_count), 32'd4);
    check_eq("mw_halted", 32'(halted), 32'd0);
    tick();

    // Timeout: ready never rises.
    dmem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1; check_eq("to_ctrl", 32'(ctrl_w), 32'(C_FREEZE));
      check_eq("to_nohalt", 32'(halted), 32'd0);
      tick();
    end
    #1;
    check_eq("to_halted", 32'(halted), 32'd1);
    check_eq("to_flag", 32'(mem_timeout), 32'd1);
    check_eq("to_cnt", 32'(stall_count), 32'd9);
    check_eq("to_hctrl", 32'(ctrl_w), 32'(C_FREEZE));
    resume = 1'b1;
    tick();
    resume = 1'b0; dmem_req = 1'b0; #1;
    check_eq("to_resume_ign", 32'(halted), 32'd1);
    check_eq("to_cnt_hold", 32'(stall_count), 32'd9);
    reset = 1'b1; #1;
    check_eq("to_rst_ctrl", 32'(ctrl_w), 32'(C_RESET));
    check_eq("to_rst_halted", 32'(halted), 32'd0);
    tick();
    reset = 1'b0; #1;
    check_eq("to_clr_flag", 32'(mem_timeout), 32'd0);
    check_eq("to_clr_cnt", 32'(stall_count), 32'd0);
    check_eq("to_clr_ctrl", 32'(ctrl_w), 32'(C_NORMAL));
    tick();

    // Ready arrives exactly in the timeout cycle.
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1; check_eq("edge_ctrl", 32'(ctrl_w), 32'(C_FREEZE));
      tick();
    end
    dmem_ready = 1'b1; #1;
    check_eq("edge_release", 32'(ctrl_w), 32'(C_NORMAL));
    tick();
    dmem_req = 1'b0; dmem_ready = 1'b0; #1;
    check_eq("edge_halted", 32'(halted), 32'd0);
    check_eq("edge_flag", 32'(mem_timeout), 32'd0);
    check_eq("edge_cnt", 32'(stall_count), 32'd4);
    tick();

    // Halt request during memory wait is deferred.
    dmem_req = 1'b1; dmem_ready = 1'b0; halt_req = 1'b1; #1;
    check_eq("hp_ctrl0", 32'(ctrl_w), 32'(C_FREEZE));
    tick();
    #1;
    check_eq("hp_nohalt1", 32'(halted), 32'd0);
    tick();
    halt_req = 1'b0; #1;
    check_eq("hp_nohalt2", 32'(halted), 32'd0);
    check_eq("hp_ctrl2", 32'(ctrl_w), 32'(C_FREEZE));
    tick();
    dmem_ready = 1'b1; #1;
    check_eq("hp_release", 32'(ctrl_w), 32'(C_NORMAL));
    tick();
    dmem_req = 1'b0; dmem_ready = 1'b0; #1;
    check_eq("hp_halted", 32'(halted), 32'd1);
    check_eq("hp_hctrl", 32'(ctrl_w), 32'(C_FREEZE));
    check_eq("hp_cnt", 32'(stall_count), 32'd7);
    resume = 1'b1;
    tick();
    resume = 1'b0; #1;
    check_eq("hp_resumed", 32'(halted), 32'd0);
    check_eq("hp_run_ctrl", 32'(ctrl_w), 32'(C_NORMAL));
    tick();

    // Halt from RUN; resume blocked while halt_req stays high.
    halt_req = 1'b1; #1;
    check_eq("hr_ctrl", 32'(ctrl_w), 32'(C_NORMAL));
    tick();
    #1;
    check_eq("hr_halted", 32'(halted), 32'd1);
    resume = 1'b1;
    tick();
    resume = 1'b0; #1;
    check_eq("hr_blocked", 32'(halted), 32'd1);
    halt_req = 1'b0;
    tick();
    tick();
    check_eq("hr_cnt", 32'(stall_count), 32'd7);
    reset = 1'b1;
    tick();
    reset = 1'b0; #1;
    check_eq("hr_rst_halted", 32'(halted), 32'd0);
    check_eq("hr_rst_cnt", 32'(stall_count), 32'd0);
    check_eq("hr_rst_ctrl", 32'(ctrl_w), 32'(C_NORMAL));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
